// File: rtl/gate_vector_checker.sv
// gate_vector_checker
//   Stimulus-and-check stage for the two-input basic-gate block. It steps
//   {a,b} through 00, 01, 10, 11, waits SETTLE_CYCLES after each step, samples
//   the seven gate outputs and compares them against golden values.
//
// Ports
//   clk, rst         clock (rising edge), synchronous active-high reset
//   start, abort     run request (taken only in IDLE) / abandon a run
//   a_drv, b_drv     drive the gate block's a/b inputs
//   gate_out[6:0]    {o6..o0} returned by the gate block
//   busy, done       run in progress / one-cycle completion pulse
//   pass             last completed run had zero mismatching bits
//   err_count[4:0]   mismatching bits accumulated over the run (0..28)
//   fail_mask[3:0]   bit v set when vector v mismatched
//   first_fail_vec   vector index of the first mismatch
//   first_fail_data  gate_out captured at the first mismatch
module gate_vector_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       a_drv,
  output logic       b_drv,
  input  logic [6:0] gate_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] fail_mask,
  output logic [1:0] first_fail_vec,
  output logic [6:0] first_fail_data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  // Counter is loaded on leaving DRIVE and the SETTLE exit fires at zero,
  // so loading SETTLE_CYCLES-1 gives exactly SETTLE_CYCLES cycles in SETTLE.
  localparam logic [CW-1:0] CNT_LOAD = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  logic [2:0]    state_q, state_d;
  logic [1:0]    v_q, v_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          a_q, a_d, b_q, b_d;
  logic          pass_q, pass_d;
  logic [4:0]    err_q, err_d;
  logic [3:0]    mask_q, mask_d;
  logic [1:0]    ffv_q, ffv_d;
  logic [6:0]    ffd_q, ffd_d;

  function automatic logic [6:0] golden(input logic [1:0] v);
    case (v)
      2'd0:    golden = 7'h71;
      2'd1:    golden = 7'h4B;
      2'd2:    golden = 7'h4A;
      default: golden = 7'h16;
    endcase
  endfunction

  function automatic logic [4:0] popcnt(input logic [6:0] x);
    popcnt = '0;
    for (int i = 0; i < 7; i++) popcnt = popcnt + {4'd0, x[i]};
  endfunction

  logic [6:0] diff;
  logic [4:0] err_sum;
  assign diff    = gate_out ^ golden(v_q);
  assign err_sum = err_q + popcnt(diff);

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    pass_d  = pass_q;
    err_d   = err_q;
    mask_d  = mask_q;
    ffv_d   = ffv_q;
    ffd_d   = ffd_q;
    case (state_q)
      S_IDLE: begin
        // start takes priority over abort here; abort means nothing in IDLE
        if (start) begin
          state_d = S_DRIVE;
          v_d     = 2'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          pass_d  = 1'b0;
          err_d   = '0;
          mask_d  = '0;
          ffv_d   = '0;
          ffd_d   = '0;
        end
      end
      S_DRIVE, S_SETTLE, S_SAMPLE: begin
        if (abort) begin
          // abandon the run: partial results stay, pass is forced low
          state_d = S_IDLE;
          v_d     = 2'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          pass_d  = 1'b0;
        end else if (state_q == S_DRIVE) begin
          // a/b were already loaded on entry, so the vector is on the pins
          // for the whole DRIVE cycle
          cnt_d   = CNT_LOAD;
          state_d = (SETTLE_CYCLES > 0) ? S_SETTLE : S_SAMPLE;
        end else if (state_q == S_SETTLE) begin
          if (cnt_q == '0) state_d = S_SAMPLE;
          else             cnt_d   = cnt_q - 1'b1;
        end else begin
          err_d = err_sum;
          if (diff != '0) begin
            mask_d[v_q] = 1'b1;
            // no earlier vector failed -> this is the first failure
            if (mask_q == '0) begin
              ffv_d = v_q;
              ffd_d = gate_out;
            end
          end
          if (v_q == 2'd3) begin
            state_d = S_DONE;
            pass_d  = (err_sum == '0);
          end else begin
            state_d    = S_DRIVE;
            v_d        = v_q + 2'd1;
            {a_d, b_d} = v_q + 2'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      v_q     <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      mask_q  <= '0;
      ffv_q   <= '0;
      ffd_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      ffv_q   <= ffv_d;
      ffd_q   <= ffd_d;
    end
  end

  assign a_drv           = a_q;
  assign b_drv           = b_q;
  assign busy            = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done            = (state_q == S_DONE);
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign fail_mask       = mask_q;
  assign first_fail_vec  = ffv_q;
  assign first_fail_data = ffd_q;

endmodule

// File: tb/tb_gate_vector_checker.sv
module tb_gate_vector_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start2 = 1'b0, abort2 = 1'b0, start0 = 1'b0, abort0 = 1'b0;

  // fault injection shared by both gate models: stuck-at-1 bits and per-vector flips
  logic [6:0]      or_m = '0;
  logic [3:0][6:0] xm   = '0;

  // independent gate model straight from the gate functions
  function automatic logic [6:0] gate_fn(input logic a, input logic b);
    return {~(a & b), ~(a | b), ~(a ^ b), a ^ b, a & b, a | b, ~a};
  endfunction

  // dut2: SETTLE_CYCLES=2, dut0: SETTLE_CYCLES=0
  logic a2, b2, busy2, done2, pass2, a0, b0, busy0, done0, pass0;
  logic [6:0] go2, go0, ffd2, ffd0;
  logic [4:0] err2, err0;
  logic [3:0] mask2, mask0;
  logic [1:0] ffv2, ffv0;

  always_comb go2 = (gate_fn(a2, b2) | or_m) ^ xm[{a2, b2}];
  always_comb go0 = (gate_fn(a0, b0) | or_m) ^ xm[{a0, b0}];

  gate_vector_checker #(.SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .a_drv(a2), .b_drv(b2),
    .gate_out(go2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_mask(mask2), .first_fail_vec(ffv2), .first_fail_data(ffd2));

  gate_vector_checker #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .a_drv(a0), .b_drv(b0),
    .gate_out(go0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_mask(mask0), .first_fail_vec(ffv0), .first_fail_data(ffd0));

  // sel 0 -> dut2, sel 1 -> dut0
  int cur = 0;
  logic a_m, b_m, busy_m, done_m, pass_m;
  logic [4:0] err_m;
  logic [3:0] mask_m;
  logic [1:0] ffv_m;
  logic [6:0] ffd_m;
  always_comb begin
    a_m = cur ? a0 : a2;       b_m = cur ? b0 : b2;
    busy_m = cur ? busy0 : busy2; done_m = cur ? done0 : done2;
    pass_m = cur ? pass0 : pass2; err_m = cur ? err0 : err2;
    mask_m = cur ? mask0 : mask2; ffv_m = cur ? ffv0 : ffv2;
    ffd_m = cur ? ffd0 : ffd2;
  end

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int              sel;
    logic [6:0]      or_m;
    logic [3:0][6:0] xm;
    logic            pass;
    logic [4:0]      err;
    logic [3:0]      mask;
    logic [1:0]      ffv;
    logic [6:0]      ffd;
  } vec_t;

  vec_t tbl[$];

  // result model for flip-only faults: count flipped bits, note first failing vector
  task automatic model(input int sel, input logic [3:0][6:0] x, output vec_t r);
    r = '{sel: sel, or_m: 7'h00, xm: x, pass: 1'b1, err: 5'd0, mask: 4'd0, ffv: 2'd0, ffd: 7'h00};
    for (int v = 0; v < 4; v++) begin
      r.err = r.err + 5'($countones(x[v]));
      if (x[v] != 0) begin
        if (r.mask == 0) begin
          r.ffv = 2'(v);
          r.ffd = gate_fn(v[1], v[0]) ^ x[v];
        end
        r.mask[v] = 1'b1;
      end
    end
    r.pass = (r.err == 0);
  endtask

  task automatic set_start(input int sel, input logic val);
    if (sel != 0) start0 = val; else start2 = val;
  endtask

  task automatic run_vec(input vec_t t, input bit mid_start);
    int per, k, dc, busybad, drvbad;
    per = (t.sel != 0) ? 2 : 4;
    k = 0; dc = 0; busybad = 0; drvbad = 0;
    cur = t.sel; or_m = t.or_m; xm = t.xm;
    set_start(t.sel, 1'b1);
    @(posedge clk); #1;
    set_start(t.sel, 1'b0);
    for (int c = 1; c <= 60; c++) begin
      if (done_m) begin dc = c; break; end
      if (!busy_m) busybad++;
      else begin
        if ({a_m, b_m} != 2'(k / per)) drvbad++;
        k++;
      end
      set_start(t.sel, mid_start && c == 3);
      @(posedge clk); #1;
    end
    set_start(t.sel, 1'b0);
    chk("done_latency", dc, 4 * per + 1);
    chk("busy_cycles", k, 4 * per);
    chk("busy_gap", busybad, 0);
    chk("drive_sequence", drvbad, 0);
    chk("pass", pass_m, t.pass);
    chk("err_count", err_m, t.err);
    chk("fail_mask", mask_m, t.mask);
    chk("first_fail_vec", ffv_m, t.ffv);
    chk("first_fail_data", ffd_m, t.ffd);
    @(posedge clk); #1;
    chk("done_single_pulse", {done_m, busy_m}, 2'b00);
    chk("drive_hold_11", {a_m, b_m}, 2'b11);
    chk("results_stable", {pass_m, err_m, mask_m, ffv_m, ffd_m},
        {t.pass, t.err, t.mask, t.ffv, t.ffd});
  endtask

  task automatic wait_vec(input logic [1:0] v, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (busy_m && {a_m, b_m} == v) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    vec_t r;
    logic [3:0][6:0] rx;
    bit ok;
    int watch;

    tbl.push_back('{sel: 0, or_m: 7'h00, xm: '0, pass: 1'b1, err: 5'd0, mask: 4'h0, ffv: 2'd0, ffd: 7'h00});
    tbl.push_back('{sel: 0, or_m: 7'h04, xm: '0, pass: 1'b0, err: 5'd3, mask: 4'b0111, ffv: 2'd0, ffd: 7'h75});
    tbl.push_back('{sel: 0, or_m: 7'h00, xm: {7'h7F, 7'h00, 7'h00, 7'h00}, pass: 1'b0, err: 5'd7, mask: 4'b1000, ffv: 2'd3, ffd: 7'h69});
    tbl.push_back('{sel: 1, or_m: 7'h04, xm: '0, pass: 1'b0, err: 5'd3, mask: 4'b0111, ffv: 2'd0, ffd: 7'h75});
    for (int i = 0; i < 8; i++) begin
      for (int v = 0; v < 4; v++) rx[v] = ($urandom_range(1) != 0) ? 7'($urandom) : 7'h00;
      model(i % 2, rx, r);
      tbl.push_back(r);
    end

    repeat (2) @(posedge clk);
    #1;
    chk("reset_dut2", {a2, b2, busy2, done2, pass2, err2, mask2, ffv2, ffd2}, '0);
    chk("reset_dut0", {a0, b0, busy0, done0, pass0, err0, mask0, ffv0, ffd0}, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) run_vec(tbl[i], 1'b0);

    // SETTLE_CYCLES=0 with start re-asserted mid-run
    model(1, '0, r);
    run_vec(r, 1'b1);

    // abort during vector 2, with abort also high on idle dut0 (no effect)
    cur = 0; or_m = 7'h00; xm = '0;
    abort0 = 1'b1;
    start2 = 1'b1; @(posedge clk); #1; start2 = 1'b0;
    wait_vec(2'b10, ok);
    chk("abort_reach_v2", ok, 1'b1);
    abort2 = 1'b1; @(posedge clk); #1; abort2 = 1'b0;
    chk("abort_idle", {busy2, done2, pass2, a2, b2}, 5'b0);
    watch = 0;
    for (int c = 0; c < 20; c++) begin
      if (done2 || busy2) watch++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", watch, 0);
    chk("abort_dut0_unaffected", {busy0, done0}, 2'b00);
    abort0 = 1'b0;
    model(0, '0, r);
    run_vec(r, 1'b0);

    // start and abort together in IDLE: start wins
    model(0, '0, r);
    abort2 = 1'b1;
    cur = 0;
    start2 = 1'b1; @(posedge clk); #1; start2 = 1'b0; abort2 = 1'b0;
    chk("start_beats_abort", busy2, 1'b1);
    for (int c = 0; c < 30 && !done2; c++) begin @(posedge clk); #1; end
    chk("start_beats_abort_done", {done2, pass2}, 2'b11);
    @(posedge clk); #1;

    // reset during SETTLE of vector 1 after v0 already mismatched
    or_m = 7'h04; xm = '0; cur = 0;
    start2 = 1'b1; @(posedge clk); #1; start2 = 1'b0;
    wait_vec(2'b01, ok);
    @(posedge clk); #1;
    chk("pre_reset_partial_err", err2, 5'd1);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    chk("midrun_reset", {a2, b2, busy2, done2, pass2, err2, mask2, ffv2, ffd2}, '0);
    model(0, '0, r);
    run_vec(r, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gate_vector_checker.md
Name: gate_vector_checker

Overview:
- Sequential stimulus-and-check stage upstream/downstream of the two-input basic-gate block.
- Drives the gate block's a/b inputs through all four input vectors and samples its seven outputs after a settle delay.
- Compares the sampled outputs against golden values and reports pass/fail, mismatch count, and first-failure details.
- Used as a self-checking wrapper on-board and in regression benches.

Parameters:
- SETTLE_CYCLES, 2, cycles between driving a vector and sampling gate_out (0 allowed).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a check run; sampled only in IDLE.
- abort  in  1  abandon a run in progress.
- a_drv  out  1  drives gate block input a.
- b_drv  out  1  drives gate block input b.
- gate_out  in  7  {o6,o5,o4,o3,o2,o1,o0} from the gate block.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run completion.
- pass  out  1  1 when the last completed run had zero mismatches.
- err_count  out  5  total mismatching bits in the last run (0..28).
- fail_mask  out  4  bit v set if vector v mismatched.
- first_fail_vec  out  2  index of first failing vector.
- first_fail_data  out  7  gate_out captured at the first failure.

Behaviour:
- Reset: synchronous, active-high, overrides everything including mid-run.
  - All outputs 0; state IDLE; vector index 0.
  - a_drv = b_drv = 0.
- Vector order: v = 0..3, with {a_drv,b_drv} = v, i.e. 00, 01, 10, 11.
- Golden {o6..o0} per vector (gate functions: o0 = !a, o1 = a|b, o2 = a&b, o3 = a^b, o4 = xnor, o5 = nor, o6 = nand):
  - v0 = 7'h71
  - v1 = 7'h4B
  - v2 = 7'h4A
  - v3 = 7'h16
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE:
  - busy = 0.
  - start = 1 → DRIVE with v = 0.
  - On accepting start, clear pass, err_count, fail_mask, first_fail_vec and first_fail_data.
- DRIVE (1 cycle):
  - a_drv/b_drv updated to vector v.
  - → SETTLE if SETTLE_CYCLES > 0, else → SAMPLE.
- SETTLE (exactly SETTLE_CYCLES cycles): down-counter, then → SAMPLE.
- SAMPLE (1 cycle):
  - Compare gate_out against golden[v].
  - err_count += popcount(gate_out ^ golden[v]).
  - On a nonzero difference, set fail_mask[v]. If this is the first failure of the run, latch first_fail_vec = v and first_fail_data = gate_out.
  - If v < 3: v++ and → DRIVE. If v == 3 → DONE.
- DONE (1 cycle):
  - done = 1; pass = (err_count == 0), using the final count including the last SAMPLE.
  - → IDLE.
- busy = 1 in DRIVE, SETTLE and SAMPLE; 0 in IDLE and DONE.
- Run latency: busy high for 4*(SETTLE_CYCLES+2) cycles, and done is the following cycle. Default: 16 busy cycles, done in cycle 17 after start is accepted.
- a_drv/b_drv hold their last vector (11) after a run until the next start or reset.
- start while busy or in DONE: ignored, not queued.
- abort while busy:
  - → IDLE next cycle, no done pulse.
  - pass = 0; other results keep partial values.
  - a_drv = b_drv = 0.
  - abort in IDLE or DONE has no effect.
- start and abort both high in IDLE: start wins, abort is ignored.
- Results (pass, err_count, fail_mask, first_fail_*) are stable from DONE until the next accepted start.
- err_count cannot overflow: max 28 < 32, no saturation logic.

Test Plan:
- Correct gate model, SETTLE_CYCLES=2, start pulse:
  - a_drv/b_drv step 00, 01, 10, 11, each held 4 cycles.
  - done pulses once, 17 cycles after start.
  - pass = 1, err_count = 0, fail_mask = 0.
- Fault injection, o2 stuck at 1:
  - Mismatch on v0, v1, v2.
  - err_count = 3, fail_mask = 4'b0111, pass = 0.
  - first_fail_vec = 0, first_fail_data = 7'h75.
- All outputs inverted on v3 only:
  - err_count = 7, fail_mask = 4'b1000.
  - first_fail_vec = 3, first_fail_data = 7'h69.
- SETTLE_CYCLES=0:
  - Each vector is held 2 cycles; busy is high 8 cycles; done in cycle 9.
  - start re-asserted mid-run is ignored, and exactly one done pulse occurs.
- abort during vector 2:
  - IDLE next cycle, no done, pass = 0, a_drv = b_drv = 0.
  - A following start runs a clean full pass with all results cleared.
- rst asserted during SETTLE:
  - Next cycle all outputs 0, state IDLE.
  - A subsequent start produces normal 17-cycle completion.
